// File: rtl/noc_out_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_out_pkg : flit type codes and lock-stage state encoding          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package noc_out_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // The type field occupies the top FLIT_TYPE_W bits of every flit.
  function automatic int type_lsb(input int flit_w);
    return flit_w - FLIT_TYPE_W;
  endfunction

  function automatic logic starts_packet(input flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_out_reg : one-entry valid/ready pipeline register                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module noc_out_reg #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // Loading is allowed while the current entry drains in the same cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_out_lock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_out_lock : wormhole output-port lock stage with one output slot; |
// | optional lock watchdog enabled by NOC_OUT_LOCK_WDOG_EN.   Rev 1.0    |
// +----------------------------------------------------------------------+
module noc_out_lock
  import noc_out_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int FLIT_W   = 34,
  parameter int WDOG_CYC = 255
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN*FLIT_W-1:0] in_flit_i,
  output logic [N_IN-1:0]        in_ready_o,
  output logic [N_IN-1:0]        req_o,
  input  logic [N_IN-1:0]        grant_i,
  output logic                   update_o,
  output logic                   out_valid_o,
  output logic [FLIT_W-1:0]      out_flit_o,
  input  logic                   out_ready_i,
  output logic                   err_o
);

  localparam int              SEL_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int              TYPE_LSB  = type_lsb(FLIT_W);
  localparam logic [N_IN-1:0] GRANT_ONE = N_IN'(1);

  generate
    if (WDOG_CYC < 1 || WDOG_CYC > 65535) begin : g_wdog_range_err
      $error("noc_out_lock: WDOG_CYC must be within 1..65535");
    end
  endgenerate

  lock_state_t       state;
  logic [SEL_W-1:0]  sel;
  logic              slot_free;
  logic              accept;
  logic [SEL_W-1:0]  acc_idx;
  logic [FLIT_W-1:0] load_flit;
  logic              grant_onehot;
  logic [SEL_W-1:0]  grant_idx;

  logic [FLIT_W-1:0] flit  [N_IN];
  flit_type_t        ftype [N_IN];

  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign flit[i]  = in_flit_i[i*FLIT_W +: FLIT_W];
      assign ftype[i] = flit_type_t'(flit[i][TYPE_LSB +: FLIT_TYPE_W]);
    end
  endgenerate

  always_comb begin
    grant_onehot = (grant_i != '0) && ((grant_i & (grant_i - GRANT_ONE)) == '0);
    grant_idx    = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_i[i]) begin
        grant_idx = SEL_W'(i);
      end
    end
  end

`ifdef NOC_OUT_LOCK_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);

  logic [15:0] wdog_cnt;
  logic        wdog_fire;
  logic        err_q;

  // Fires on the idle cycle that would bring the stall count to WDOG_CYC.
  assign wdog_fire = (state == LOCKED) && !in_valid_i[sel] && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != LOCKED || accept || wdog_fire) begin
        wdog_cnt <= '0;
      end else if (!in_valid_i[sel]) begin
        wdog_cnt <= wdog_cnt + 16'd1;
      end
      if (wdog_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    req_o      = '0;
    in_ready_o = '0;
    update_o   = 1'b0;
    accept     = 1'b0;
    acc_idx    = sel;
    if (arst_n) begin
      case (state)
        IDLE: begin
          for (int i = 0; i < N_IN; i++) begin
            req_o[i] = in_valid_i[i] && starts_packet(ftype[i]);
          end
          if (grant_onehot && ((grant_i & req_o) != '0) && slot_free) begin
            in_ready_o = grant_i;
            accept     = 1'b1;
            acc_idx    = grant_idx;
            update_o   = (ftype[grant_idx] == HEADTAIL);
          end
        end
        LOCKED: begin
`ifdef NOC_OUT_LOCK_WDOG_EN
          if (wdog_fire) begin
            update_o = 1'b1;
          end else
`endif
          begin
            // A stray HEAD/HEADTAIL here is forwarded as if it were BODY.
            in_ready_o[sel] = slot_free;
            if (in_valid_i[sel] && slot_free) begin
              accept   = 1'b1;
              update_o = (ftype[sel] == TAIL);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign load_flit = flit[acc_idx];

  // Every update pulse ends a lock (or a single-flit packet); a plain HEAD starts one.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= IDLE;
      sel   <= '0;
    end else if (update_o) begin
      state <= IDLE;
    end else if (accept && state == IDLE) begin
      state <= LOCKED;
      sel   <= acc_idx;
    end
  end

  noc_out_reg #(
    .WIDTH (FLIT_W)
  ) u_out_reg (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (accept),
    .in_data   (load_flit),
    .in_ready  (slot_free),
    .out_valid (out_valid_o),
    .out_data  (out_flit_o),
    .out_ready (out_ready_i)
  );

endmodule
`default_nettype wire
